// File: rtl/rng_pkg.sv
// Shared definitions for the arbitrated random-number source: LFSR geometry,
// default seed and the controller state encoding.
package rng_pkg;

  localparam int unsigned LFSR_W = 32;
  localparam int unsigned TAP_A  = 31;
  localparam int unsigned TAP_B  = 21;
  localparam int unsigned TAP_C  = 1;
  localparam int unsigned TAP_D  = 0;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_SERVE  = 2'd1,
    ST_SEED   = 2'd2
  } rng_state_e;

  // One Fibonacci step: shift left, feedback into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/rng_lfsr.sv
// 32-bit Fibonacci LFSR with step enable and a zero-guarded synchronous load.
// An all-zero state would lock up, so zero seeds are replaced with 1.
module rng_lfsr
  import rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_step,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_load_data,
  output logic [LFSR_W-1:0] o_state
);

  localparam logic [LFSR_W-1:0] RST_VAL = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] r_state;

  // Load wins over step so a seed is never perturbed in its load cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RST_VAL;
    end else if (i_load) begin
      r_state <= (i_load_data == '0) ? LFSR_W'(1) : i_load_data;
    end else if (i_step) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin distribution of LFSR words to NUM_REQ requesters. The LFSR only
// advances on a grant, so every handed-out word is unique to its requester.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int unsigned      NUM_REQ       = 4,
  parameter int unsigned      WIDTH         = 32,
  parameter logic [WIDTH-1:0] SEED          = 32'h0000_0001,
  parameter int unsigned      WARMUP_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               seed_valid,
  input  logic [WIDTH-1:0]   seed_data,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [WIDTH-1:0]   rnd_data,
  output logic               ready
);

  // The feedback taps are only meaningful for WIDTH == LFSR_W.
  localparam int unsigned PTR_W    = $clog2(NUM_REQ);
  localparam int unsigned IDX_W    = PTR_W + 1;
  localparam int unsigned CNT_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP_CYCLES);
  localparam bit NO_WARMUP = (WARMUP_CYCLES == 0);

  rng_state_e         r_state;
  rng_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic [WIDTH-1:0]   r_rnd;
  logic [WIDTH-1:0]   w_rnd_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               r_ready;
  logic               w_ready_nxt;

  logic               w_step;
  logic               w_load;
  logic [LFSR_W-1:0]  w_lfsr;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_rot;
  logic [PTR_W-1:0]   w_off;
  logic [IDX_W-1:0]   w_sum;
  logic [PTR_W-1:0]   w_gnt;
  logic [PTR_W-1:0]   w_ptr_adv;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_any;

  rng_lfsr #(
    .SEED(LFSR_W'(SEED))
  ) u_lfsr (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_step      (w_step),
    .i_load      (w_load),
    .i_load_data (LFSR_W'(seed_data)),
    .o_state     (w_lfsr)
  );

  // Rotate eligible so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    w_elig = req & ~r_ack;
    w_any  = |w_elig;
    w_rot  = NUM_REQ'({w_elig, w_elig} >> r_ptr);
    w_off  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PTR_W'(k);
    end
    w_sum     = IDX_W'(r_ptr) + IDX_W'(w_off);
    w_gnt     = (w_sum >= IDX_W'(NUM_REQ)) ? PTR_W'(w_sum - IDX_W'(NUM_REQ)) : PTR_W'(w_sum);
    w_ptr_adv = (w_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt + PTR_W'(1);
    w_onehot  = NUM_REQ'(1) << w_gnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_WARMUP;
    else          r_state <= w_state_nxt;
  end

  // Next state and next register values; a seed pre-empts everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = '0;
    w_rnd_nxt   = r_rnd;
    w_ptr_nxt   = r_ptr;
    w_step      = 1'b0;
    w_load      = 1'b0;
    if (seed_valid) begin
      w_load      = 1'b1;
      w_cnt_nxt   = CNT_INIT;
      w_state_nxt = ST_SEED;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_SERVE;
          end else begin
            w_step    = 1'b1;
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) w_state_nxt = ST_SERVE;
          end
        end
        // A zero-length warm-up skips WARMUP so ready still rises one cycle on.
        ST_SEED: w_state_nxt = NO_WARMUP ? ST_SERVE : ST_WARMUP;
        ST_SERVE: begin
          if (w_any) begin
            w_ack_nxt = w_onehot;
            w_rnd_nxt = WIDTH'(w_lfsr);
            w_step    = 1'b1;
            w_ptr_nxt = w_ptr_adv;
          end
        end
        default: w_state_nxt = ST_WARMUP;
      endcase
    end
    w_ready_nxt = (w_state_nxt == ST_SERVE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= CNT_INIT;
      r_ack   <= '0;
      r_rnd   <= '0;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_rnd   <= w_rnd_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign ack      = r_ack;
  assign rnd_data = r_rnd;
  assign ready    = r_ready;

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: a zero-warm-up instance checked cycle by cycle against
// a behavioural model, plus a 64-cycle warm-up instance for warm-up timing.
module tb_rng_arbiter;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic [3:0]  req;
  logic [3:0]  ack0, ack64;
  logic [31:0] rnd0, rnd64;
  logic        rdy0, rdy64;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the zero-warm-up instance.
  logic [31:0] m_lfsr, m_rnd;
  logic [3:0]  m_ack;
  logic        m_ready;
  int          m_ptr;
  int          m_wait;

  always #5 clk = ~clk;

  rng_arbiter #(.NUM_REQ(4), .WIDTH(32), .SEED(32'h1), .WARMUP_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .seed_valid(seed_valid), .seed_data(seed_data),
    .req(req), .ack(ack0), .rnd_data(rnd0), .ready(rdy0));

  rng_arbiter #(.NUM_REQ(4), .WIDTH(32), .SEED(32'h1), .WARMUP_CYCLES(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .seed_valid(seed_valid), .seed_data(seed_data),
    .req(req), .ack(ack64), .rnd_data(rnd64), .ready(rdy64));

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic model_reset();
    m_lfsr = 32'h1; m_rnd = '0; m_ack = '0; m_ptr = 0; m_ready = 1'b0; m_wait = 1;
  endtask

  task automatic model_edge();
    logic [3:0] elig;
    int pick;
    if (seed_valid) begin
      m_lfsr = (seed_data == 0) ? 32'h1 : seed_data;
      m_ack = '0; m_ready = 1'b0; m_wait = 1;
    end else if (m_wait > 0) begin
      m_wait--; m_ack = '0;
      if (m_wait == 0) m_ready = 1'b1;
    end else begin
      elig = req & ~m_ack;
      pick = -1;
      for (int k = 0; k < NREQ; k++)
        if (pick < 0 && elig[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
      if (pick >= 0) begin
        m_ack = 4'(1) << pick; m_rnd = m_lfsr; m_lfsr = lfsr_next(m_lfsr);
        m_ptr = (pick + 1) % NREQ;
      end else begin
        m_ack = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    model_edge();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; seed_valid = 1'b0; seed_data = '0; req = '0;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; req = '0; seed_valid = 1'b0; seed_data = '0;
    #1;
    tests++; if (ack0 !== 4'b0)  begin fails++; $display("FAIL reset_ack0: got %b want 0000", ack0); end
    tests++; if (rnd0 !== 32'b0) begin fails++; $display("FAIL reset_rnd0: got %h want 0", rnd0); end
    tests++; if (rdy0 !== 1'b0)  begin fails++; $display("FAIL reset_rdy0: got %b want 0", rdy0); end
    tests++; if (ack64 !== 4'b0)  begin fails++; $display("FAIL reset_ack64: got %b want 0000", ack64); end
    tests++; if (rnd64 !== 32'b0) begin fails++; $display("FAIL reset_rnd64: got %h want 0", rnd64); end
    tests++; if (rdy64 !== 1'b0)  begin fails++; $display("FAIL reset_rdy64: got %b want 0", rdy64); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_req();
    logic [31:0] exp_w [5];
    logic [31:0] got [$];
    exp_w = '{32'h1, 32'h3, 32'h6, 32'hD, 32'h1B};
    do_reset();
    req = 4'b0001;
    for (int e = 0; e < 10; e++) begin
      tick();
      tests++;
      if ({ack0, rnd0, rdy0} !== {m_ack, m_rnd, m_ready}) begin
        fails++;
        $display("FAIL single_model e=%0d: ack=%b rnd=%h rdy=%b want ack=%b rnd=%h rdy=%b",
                 e, ack0, rnd0, rdy0, m_ack, m_rnd, m_ready);
      end
      if (ack0 != 4'b0) got.push_back(rnd0);
    end
    tests++;
    if (got.size() != 5) begin fails++; $display("FAIL single_count: got %0d grants want 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      tests++;
      if (got[k] !== exp_w[k]) begin fails++; $display("FAIL single_word%0d: got %h want %h", k, got[k], exp_w[k]); end
    end
    req = '0;
  endtask

  task automatic test_all_req();
    logic [31:0] exp_w [5];
    int n;
    exp_w = '{32'h1, 32'h3, 32'h6, 32'hD, 32'h1B};
    n = 0;
    do_reset();
    req = 4'b1111;
    tick();
    for (int e = 0; e < 7; e++) begin
      tick();
      tests++;
      if (ack0 !== (4'(1) << (n % NREQ)) || !$onehot(ack0)) begin
        fails++; $display("FAIL all_order g=%0d: ack=%b want %b", n, ack0, 4'(1) << (n % NREQ));
      end
      if (n < 5) begin
        tests++;
        if (rnd0 !== exp_w[n]) begin fails++; $display("FAIL all_word%0d: got %h want %h", n, rnd0, exp_w[n]); end
      end
      n++;
    end
    req = '0;
  endtask

  task automatic test_warmup64();
    logic [31:0] w;
    w = 32'h1;
    for (int k = 0; k < 64; k++) w = lfsr_next(w);
    do_reset();
    req = 4'b0001;
    #1;
    tests++; if (rdy64 !== 1'b0) begin fails++; $display("FAIL warm_rdy_start: got %b want 0", rdy64); end
    for (int e = 1; e <= 64; e++) begin
      tick();
      tests++;
      if (ack64 !== 4'b0 || rdy64 !== (e == 64)) begin
        fails++; $display("FAIL warm_idle e=%0d: ack=%b rdy=%b want ack=0000 rdy=%b", e, ack64, rdy64, e == 64);
      end
    end
    tick();
    tests++;
    if (ack64 !== 4'b0001 || rnd64 !== w) begin
      fails++; $display("FAIL warm_first: ack=%b rnd=%h want ack=0001 rnd=%h", ack64, rnd64, w);
    end
    req = '0;
  endtask

  task automatic test_seed_zero();
    do_reset();
    req = 4'b0001;
    for (int e = 0; e < 6; e++) begin
      tick();
      tests++;
      if ({ack0, rnd0, rdy0} !== {m_ack, m_rnd, m_ready}) begin
        fails++; $display("FAIL seed_pre e=%0d: ack=%b rnd=%h want ack=%b rnd=%h", e, ack0, rnd0, m_ack, m_rnd);
      end
    end
    req = 4'b0010; seed_valid = 1'b1; seed_data = '0;
    tick();
    seed_valid = 1'b0;
    tests++;
    if (ack0 !== 4'b0 || rdy0 !== 1'b0) begin
      fails++; $display("FAIL seed_edge: ack=%b rdy=%b want ack=0000 rdy=0", ack0, rdy0);
    end
    tick();
    tests++;
    if (ack0 !== 4'b0 || rdy0 !== 1'b1) begin
      fails++; $display("FAIL seed_warm: ack=%b rdy=%b want ack=0000 rdy=1", ack0, rdy0);
    end
    tick();
    tests++;
    if (ack0 !== 4'b0010 || rnd0 !== 32'h1) begin
      fails++; $display("FAIL seed_serve: ack=%b rnd=%h want ack=0010 rnd=00000001", ack0, rnd0);
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    tests++;
    if (ack0 !== 4'b0001 || rnd0 !== 32'h3) begin
      fails++; $display("FAIL mid_pre: ack=%b rnd=%h want ack=0001 rnd=00000003", ack0, rnd0);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (ack0 !== 4'b0 || rnd0 !== 32'b0 || rdy0 !== 1'b0) begin
      fails++; $display("FAIL mid_async: ack=%b rnd=%h rdy=%b want all 0", ack0, rnd0, rdy0);
    end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    tick();
    tests++;
    if (ack0 !== 4'b0001 || rnd0 !== 32'h1) begin
      fails++; $display("FAIL mid_restart: ack=%b rnd=%h want ack=0001 rnd=00000001", ack0, rnd0);
    end
    req = '0;
  endtask

  task automatic test_pulse();
    int n;
    bit served;
    do_reset();
    req = 4'b0001;
    tick();
    for (int t = 0; t < 6; t++) begin
      req[2] = 1'b1;
      served = 1'b0;
      n = 0;
      while (!served && n < 4) begin
        tick();
        n++;
        tests++;
        if ({ack0, rnd0} !== {m_ack, m_rnd}) begin
          fails++; $display("FAIL pulse_model t=%0d: ack=%b rnd=%h want ack=%b rnd=%h", t, ack0, rnd0, m_ack, m_rnd);
        end
        if (ack0[2]) served = 1'b1;
      end
      tests++;
      if (!served || n > 2) begin fails++; $display("FAIL pulse_latency t=%0d: served=%0b after %0d cycles want <=2", t, served, n); end
      req[2] = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    req = '0;
  endtask

  task automatic test_random();
    int waits [NREQ];
    int max_wait;
    logic prev_ready;
    logic sv;
    max_wait = 0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    do_reset();
    tick();
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (ack0[i]) req[i] = 1'($urandom_range(0, 1));
        end else begin
          req[i] = ($urandom_range(0, 2) == 0);
        end
      end
      seed_valid = ($urandom_range(0, 99) == 0);
      seed_data = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      prev_ready = m_ready;
      sv = seed_valid;
      tick();
      tests++;
      if ({ack0, rnd0, rdy0} !== {m_ack, m_rnd, m_ready}) begin
        fails++;
        $display("FAIL random_model c=%0d: ack=%b rnd=%h rdy=%b want ack=%b rnd=%h rdy=%b",
                 c, ack0, rnd0, rdy0, m_ack, m_rnd, m_ready);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || ack0[i] || sv || !prev_ready) waits[i] = 0;
        else waits[i]++;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
    end
    seed_valid = 1'b0;
    tests++;
    if (max_wait > NREQ) begin fails++; $display("FAIL random_starve: max wait %0d cycles want <=%0d", max_wait, NREQ); end
    req = '0;
  endtask

  initial begin
    reset_n = 1'b0; seed_valid = 1'b0; seed_data = '0; req = '0;
    model_reset();
    test_reset();
    test_single_req();
    test_all_req();
    test_warmup64();
    test_seed_zero();
    test_reset_mid();
    test_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded 1 ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rng_arbiter.md
# rng_arbiter

Shares one 32-bit Fibonacci LFSR random-number source among NUM_REQ requesters, such as the WalkSAT variable-pick and clause-select units. Grants are round-robin, and the LFSR advances only when a word is handed out, so no two requesters ever receive the same word. The block also sequences seeding and a post-seed warm-up. It sits between the solver's per-unit control FSMs and the random source.

## Interface
- NUM_REQ, 4: number of requesters (2..16).
- WIDTH, 32: random word width. The polynomial is fixed for 32.
- SEED, 32'h0000_0001: LFSR state after reset.
- WARMUP_CYCLES, 64: free-running LFSR steps after reset or seed load before serving. 0 is legal.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- seed_valid  in  1  one-cycle pulse: load seed_data.
- seed_data  in  WIDTH  new seed.
- req  in  NUM_REQ  per-requester request level.
- ack  out  NUM_REQ  one-hot (or zero), one-cycle grant pulse. Registered.
- rnd_data  out  WIDTH  random word, valid in the cycle ack is high. Registered.
- ready  out  1  high in SERVE state.

## Operation
- LFSR step: next = {state[30:0], state[31]^state[21]^state[1]^state[0]}.
- FSM states:
  - WARMUP: counter runs from WARMUP_CYCLES down to 0, the LFSR steps every cycle, and no grants are issued. Exit to SERVE when the counter reaches 0; with WARMUP_CYCLES=0, enter SERVE on the first clock edge.
  - SERVE: at each edge, eligible = req & ~ack. If eligible ≠ 0, pick the first set bit at or after ptr (wrapping). Set ack[i]=1 and rnd_data = current LFSR state, step the LFSR once, and set ptr = (i+1) mod NUM_REQ. If eligible = 0, ack=0, the LFSR holds, and rnd_data holds.
  - SEED: entered from any state on seed_valid. Load the LFSR with seed_data, or with 32'h1 if seed_data = 0. Clear ack, reload the warm-up counter, and go to WARMUP next cycle. The seed has priority over a grant in the same cycle; that request stays pending.
- Handshake: a requester holds req until it sees ack. The arbiter masks requester i in the cycle its ack is high. If req[i] is still high in the following cycle, it is a new request.
- ptr resets to 0 and is unchanged by seeding.
- Reset values: ack=0, rnd_data=0, ready=0, LFSR=SEED (0 is forced to 1), ptr=0, state=WARMUP with counter=WARMUP_CYCLES.
- Reset mid-operation: everything returns to the reset values asynchronously. Any outstanding ack is dropped; requesters re-request.

## Timing
- Latency: req rises before edge t, and ack plus rnd_data appear after edge t (1 cycle) if uncontended.
- Throughput: one grant per cycle overall. A single requester holding req continuously gets an ack every other cycle.
- Worst-case wait with all requesters busy: NUM_REQ cycles.
- ready falls in the cycle after seed_valid. It rises WARMUP_CYCLES+1 cycles later.

## Structure
- Shared package rng_pkg: LFSR width, tap positions (31,21,1,0), default seed, and the state enum (WARMUP, SERVE, SEED).
- Sub-module rng_lfsr: step enable, synchronous load with zero-guard, asynchronous reset to SEED, and exposes its state.
- The arbiter (rotate, priority-find, rotate back) stays inline.

## Test plan
- WARMUP_CYCLES=0, reset, req=4'b0001 held → acks on alternate cycles with rnd_data 0x1, 0x3, 0x6, 0xD, 0x1B.
- WARMUP_CYCLES=0, req=4'b1111 held → grant order 0,1,2,3,0,… with rnd_data 0x1,0x3,0x6,0xD,0x1B; never two acks at once.
- WARMUP_CYCLES=64 → ready=0 and no ack for 64 cycles after reset release. The first ack's word equals the 65th LFSR state from 0x1.
- seed_valid with seed_data=0 in the same cycle as a pending req → no ack that cycle. After warm-up, the LFSR restarts from 0x1 and the request is then served.
- reset_n asserted while ack is high → ack and rnd_data go to 0 immediately. After release, the sequence restarts from SEED.
- req[2] pulses only, while req[0] is held → req[2] is served within 2 cycles; ptr fairness holds over 1000 random cycles, with no requester starved beyond NUM_REQ cycles.
